// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_pkg                                                      |
// | Description : Shared encodings for the MIPS memory stage: access-size      |
// |               codes, handshake FSM states and pipeline bus widths.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_pkg;

    // Access size field encodings carried on the EXE->MEM bus
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Pipeline bus widths
    localparam int EXE_MEM_W = 107;
    localparam int MEM_WB_W  = 70;

    // Memory-stage handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_lane_align                                               |
// | Description : Purely combinational byte-lane logic. Produces store lane    |
// |               enables and replicated store data, extracts and extends      |
// |               load data, and flags misaligned half/word accesses.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_lane_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_mis
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Misalignment: halves need an even address, words a 4-byte aligned one
    always_comb begin
        o_mis = 1'b0;
        if (i_size == SZ_H)
            o_mis = i_addr_lo[0];
        else if (i_size == SZ_W)
            o_mis = (i_addr_lo != 2'b00);
    end

    // Store side: lane enables and lane-replicated write data
    always_comb begin
        o_lane_en = 4'b1111;
        o_wdata   = i_store_data;
        case (i_size)
            SZ_B: begin
                o_lane_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_store_data[7:0]}};
            end
            SZ_H: begin
                o_lane_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_store_data[15:0]}};
            end
            default: begin
                o_lane_en = 4'b1111;
                o_wdata   = i_store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane and zero/sign extend
    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_B:    o_load_data = {{24{i_sign & w_byte[7]}}, w_byte};
            SZ_H:    o_load_data = {{16{i_sign & w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_lsu                                                |
// | Description : MIPS memory stage between EXE and WB. Sub-word load/store    |
// |               decode, misalignment flagging, byte-lane data-memory drive   |
// |               and a parametrised load-latency handshake FSM.               |
// |               Optional macro MEM_LOAD_CAPTURE_EN registers extracted load  |
// |               data at completion (result appears one cycle later).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_valid,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
    input  logic [31:0]          dm_rdata,
    output logic [31:0]          dm_addr,
    output logic [3:0]           dm_wen,
    output logic [31:0]          dm_wdata,
    output logic                 MEM_over,
    output logic                 MEM_exc,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [31:0]          MEM_pc
);

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'((LOAD_LAT > 0) ? LOAD_LAT - 1 : 0);
`ifdef MEM_LOAD_CAPTURE_EN
    localparam logic c_CAPTURE = 1'b1;
`else
    localparam logic c_CAPTURE = 1'b0;
`endif

    // EXE->MEM bus fields
    logic        w_ld;
    logic        w_st;
    logic [1:0]  w_size;
    logic        w_sign;
    logic [31:0] w_sd;
    logic [31:0] w_alu;
    logic        w_rf_wen;
    logic [4:0]  w_rf_wdest;
    logic [31:0] w_pc;

    assign w_ld       = EXE_MEM_bus_r[106];
    assign w_st       = EXE_MEM_bus_r[105];
    assign w_size     = EXE_MEM_bus_r[104:103];
    assign w_sign     = EXE_MEM_bus_r[102];
    assign w_sd       = EXE_MEM_bus_r[101:70];
    assign w_alu      = EXE_MEM_bus_r[69:38];
    assign w_rf_wen   = EXE_MEM_bus_r[37];
    assign w_rf_wdest = EXE_MEM_bus_r[36:32];
    assign w_pc       = EXE_MEM_bus_r[31:0];

    logic [3:0]  w_lane_en;
    logic [31:0] w_load_data;
    logic [31:0] w_load_result;
    logic        w_mis;
    logic        w_load_ok;

    mem_lane_align u_align (
        .i_size       (w_size),
        .i_addr_lo    (w_alu[1:0]),
        .i_sign       (w_sign),
        .i_store_data (w_sd),
        .i_rdata      (dm_rdata),
        .o_lane_en    (w_lane_en),
        .o_wdata      (dm_wdata),
        .o_load_data  (w_load_data),
        .o_mis        (w_mis)
    );

    // Only aligned loads have to wait for the memory
    assign w_load_ok = w_ld & ~w_mis;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_over_raw;
    logic             w_store_fire;

    // State and load-wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state, counter and completion/store-strobe decode
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_over_raw   = 1'b0;
        w_store_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MEM_valid) begin
                    w_store_fire = w_st & ~w_mis;
                    if (!w_load_ok) begin
                        w_over_raw   = 1'b1;
                        w_next_state = ST_DONE;
                    end else if (LOAD_LAT == 0) begin
                        // Data already valid; with capture it shows next cycle
                        w_over_raw   = ~c_CAPTURE;
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = c_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!MEM_valid) begin
                    // Flush: abandon the load silently
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == '0) begin
                    w_over_raw   = ~c_CAPTURE;
                    w_next_state = ST_DONE;
                end else begin
                    w_next_cnt   = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                if (MEM_valid)
                    w_over_raw   = 1'b1;
                else
                    w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

`ifdef MEM_LOAD_CAPTURE_EN
    logic [31:0] r_load_q;
    logic        w_cap_load;

    // Completion edge of an aligned load: immediate (LOAD_LAT=0) or end of WAIT
    assign w_cap_load = MEM_valid & ~rst &
                        (((r_state == ST_IDLE) & w_load_ok & (LOAD_LAT == 0)) |
                         ((r_state == ST_WAIT) & (r_cnt == '0)));

    // Capture extracted load data at completion and hold it through DONE
    always_ff @(posedge clk) begin
        if (rst)
            r_load_q <= '0;
        else if (w_cap_load)
            r_load_q <= w_load_data;
    end

    assign w_load_result = w_load_ok ? r_load_q : w_load_data;
`else
    assign w_load_result = w_load_data;
`endif

    // Reset overrides completion and store strobes in the same cycle
    assign MEM_over   = w_over_raw & ~rst;
    assign dm_wen     = (w_store_fire & ~rst) ? w_lane_en : 4'b0000;
    assign dm_addr    = w_alu;
    assign MEM_exc    = w_mis & (w_ld | w_st);
    assign MEM_pc     = w_pc;
    assign MEM_WB_bus = {w_rf_wen & ~(w_ld & w_mis), w_rf_wdest,
                         (w_ld ? w_load_result : w_alu), w_pc};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage_lsu                                             |
// | Description : Self-checking bench for mem_stage_lsu. Three instances with  |
// |               LOAD_LAT = 1, 3, 0 share stimulus; directed scenarios plus   |
// |               randomized transactions against a reference model.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage_lsu;
    import mem_pkg::*;

`ifdef MEM_LOAD_CAPTURE_EN
    localparam int CAP = 1;
`else
    localparam int CAP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              MEM_valid;
    logic [106:0]      bus;
    logic [31:0]       dm_rdata;
    logic [2:0][31:0]  addr_a;
    logic [2:0][31:0]  wdata_a;
    logic [2:0][31:0]  pc_a;
    logic [2:0][3:0]   wen_a;
    logic [2:0]        over_a;
    logic [2:0]        exc_a;
    logic [2:0][69:0]  wb_a;
    int                npass  = 0;
    int                ntotal = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_lsu #(
            .LOAD_LAT ((g == 0) ? 1 : (g == 1) ? 3 : 0),
            .CNT_W    (3)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .MEM_valid     (MEM_valid),
            .EXE_MEM_bus_r (bus),
            .dm_rdata      (dm_rdata),
            .dm_addr       (addr_a[g]),
            .dm_wen        (wen_a[g]),
            .dm_wdata      (wdata_a[g]),
            .MEM_over      (over_a[g]),
            .MEM_exc       (exc_a[g]),
            .MEM_WB_bus    (wb_a[g]),
            .MEM_pc        (pc_a[g])
        );
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 3 : 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] sd, input logic [31:0] alu, input logic rfw,
                           input logic [4:0] dst, input logic [31:0] pc);
        bus = {ld, st, sz, sg, sd, alu, rfw, dst, pc};
    endtask

    task automatic test_reset;
        rst = 1'b1; MEM_valid = 1'b0; bus = '0; dm_rdata = $urandom;
        tick; tick;
        @(negedge clk);
        ntotal++; if (over_a !== 3'b000) $display("FAIL reset_over: got %b expected 000", over_a); else npass++;
        ntotal++; if (wen_a !== 12'h000) $display("FAIL reset_wen: got %h expected 000", wen_a); else npass++;
        ntotal++; if (wb_a !== '0) $display("FAIL reset_wb: got %h expected 0", wb_a); else npass++;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_lb;
        logic e;
        set_bus(1, 0, SZ_B, 1, 32'h0, 32'h1003, 1, 5'd7, 32'h400);
        dm_rdata = 32'h80FF1234; MEM_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            e = (t >= 1 + CAP);
            ntotal++; if (over_a[0] !== e) $display("FAIL lb_over c%0d: got %b expected %b", t, over_a[0], e); else npass++;
            if (e) begin
                ntotal++; if (wb_a[0][63:32] !== 32'hFFFFFF80) $display("FAIL lb_result: got %h expected ffffff80", wb_a[0][63:32]); else npass++;
            end
            tick;
        end
        MEM_valid = 1'b0; tick;
    endtask

    task automatic test_lhu;
        logic e;
        set_bus(1, 0, SZ_H, 0, 32'h0, 32'h2002, 1, 5'd9, 32'h404);
        dm_rdata = 32'hBEEF0000; MEM_valid = 1'b1;
        for (int t = 0; t < 2 + CAP; t++) begin
            @(negedge clk);
            e = (t >= 1 + CAP);
            ntotal++; if (exc_a[0] !== 1'b0) $display("FAIL lhu_exc: got %b expected 0", exc_a[0]); else npass++;
            ntotal++; if (over_a[0] !== e) $display("FAIL lhu_over c%0d: got %b expected %b", t, over_a[0], e); else npass++;
            if (e) begin
                ntotal++; if (wb_a[0][63:32] !== 32'h0000BEEF) $display("FAIL lhu_result: got %h expected 0000beef", wb_a[0][63:32]); else npass++;
            end
            tick;
        end
        MEM_valid = 1'b0; tick;
    endtask

    task automatic test_sh_hold;
        logic [3:0] ew;
        set_bus(0, 1, SZ_H, 0, 32'h1234ABCD, 32'h0006, 0, 5'd0, 32'h408);
        for (int t = 0; t < 4; t++) begin
            MEM_valid = (t < 3);
            @(negedge clk);
            ew = (t == 0) ? 4'b1100 : 4'b0000;
            ntotal++; if (wen_a[0] !== ew) $display("FAIL sh_wen c%0d: got %b expected %b", t, wen_a[0], ew); else npass++;
            ntotal++; if (over_a[0] !== (t < 3)) $display("FAIL sh_over c%0d: got %b expected %b", t, over_a[0], (t < 3)); else npass++;
            if (t == 0) begin
                ntotal++; if (wdata_a[0] !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h expected abcdabcd", wdata_a[0]); else npass++;
            end
            tick;
        end
    endtask

    task automatic test_misaligned;
        set_bus(0, 1, SZ_W, 0, 32'h55AA55AA, 32'h0005, 0, 5'd0, 32'h40C);
        MEM_valid = 1'b1;
        @(negedge clk);
        ntotal++; if (wen_a[0] !== 4'b0000) $display("FAIL sw_mis_wen: got %b expected 0000", wen_a[0]); else npass++;
        ntotal++; if (over_a[0] !== 1'b1) $display("FAIL sw_mis_over: got %b expected 1", over_a[0]); else npass++;
        ntotal++; if (exc_a[0] !== 1'b1) $display("FAIL sw_mis_exc: got %b expected 1", exc_a[0]); else npass++;
        tick; MEM_valid = 1'b0; tick;
        set_bus(1, 0, SZ_W, 0, 32'h0, 32'h0002, 1, 5'd3, 32'h410);
        MEM_valid = 1'b1;
        @(negedge clk);
        ntotal++; if (over_a[0] !== 1'b1) $display("FAIL lw_mis_over: got %b expected 1", over_a[0]); else npass++;
        ntotal++; if (exc_a[0] !== 1'b1) $display("FAIL lw_mis_exc: got %b expected 1", exc_a[0]); else npass++;
        ntotal++; if (wb_a[0][69] !== 1'b0) $display("FAIL lw_mis_rfwen: got %b expected 0", wb_a[0][69]); else npass++;
        tick; MEM_valid = 1'b0; tick;
    endtask

    task automatic test_flush_reset;
        logic e;
        set_bus(1, 0, SZ_W, 0, 32'h0, 32'h0010, 1, 5'd4, 32'h414);
        dm_rdata = 32'h01020304;
        for (int t = 0; t < 6; t++) begin
            MEM_valid = (t < 2);
            @(negedge clk);
            ntotal++; if (over_a[1] !== 1'b0) $display("FAIL flush_over c%0d: got %b expected 0", t, over_a[1]); else npass++;
            tick;
        end
        MEM_valid = 1'b1;
        for (int t = 0; t <= 5 + CAP; t++) begin
            rst = (t == 1);
            @(negedge clk);
            e = (t == 5 + CAP);
            ntotal++; if (over_a[1] !== e) $display("FAIL rst_over c%0d: got %b expected %b", t, over_a[1], e); else npass++;
            tick;
        end
        rst = 1'b0; MEM_valid = 1'b0; tick; tick;
    endtask

    task automatic test_lat0;
        logic        e;
        logic [31:0] er;
        set_bus(1, 0, SZ_W, 0, 32'h0, 32'h0040, 1, 5'd5, 32'h418);
        dm_rdata = 32'hCAFEF00D; MEM_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            if (t == 2) dm_rdata = 32'h12345678;
            @(negedge clk);
            e  = (t >= CAP);
            er = (t == 2 && CAP == 0) ? 32'h12345678 : 32'hCAFEF00D;
            ntotal++; if (over_a[2] !== e) $display("FAIL lat0_over c%0d: got %b expected %b", t, over_a[2], e); else npass++;
            if (e) begin
                ntotal++; if (wb_a[2][63:32] !== er) $display("FAIL lat0_result c%0d: got %h expected %h", t, wb_a[2][63:32], er); else npass++;
            end
            tick;
        end
        MEM_valid = 1'b0; tick;
    endtask

    task automatic test_back_to_back;
        set_bus(0, 1, SZ_W, 0, 32'h11223344, 32'h0020, 0, 5'd0, 32'h41C);
        MEM_valid = 1'b1;
        @(negedge clk);
        ntotal++; if (wen_a[0] !== 4'b1111) $display("FAIL b2b_wen0: got %b expected 1111", wen_a[0]); else npass++;
        tick;
        @(negedge clk);
        ntotal++; if (wen_a[0] !== 4'b0000) $display("FAIL b2b_wen1: got %b expected 0000", wen_a[0]); else npass++;
        ntotal++; if (over_a[0] !== 1'b1) $display("FAIL b2b_over1: got %b expected 1", over_a[0]); else npass++;
        tick; MEM_valid = 1'b0;
        @(negedge clk);
        ntotal++; if (over_a[0] !== 1'b0) $display("FAIL b2b_over2: got %b expected 0", over_a[0]); else npass++;
        tick;
        set_bus(0, 1, SZ_B, 0, 32'h000000AB, 32'h0021, 0, 5'd0, 32'h420);
        MEM_valid = 1'b1;
        @(negedge clk);
        ntotal++; if (wen_a[0] !== 4'b0010) $display("FAIL b2b_wen3: got %b expected 0010", wen_a[0]); else npass++;
        ntotal++; if (wdata_a[0] !== 32'hABABABAB) $display("FAIL b2b_wdata3: got %h expected abababab", wdata_a[0]); else npass++;
        ntotal++; if (over_a[0] !== 1'b1) $display("FAIL b2b_over3: got %b expected 1", over_a[0]); else npass++;
        tick; MEM_valid = 1'b0; tick;
    endtask

    task automatic test_random;
        int          idx, lat, kind, d, T;
        logic        ld, st, sg, rfw, mis, eo;
        logic [1:0]  sz;
        logic [4:0]  dst;
        logic [31:0] alu, sd, rd, pc, v, eres, ewd, lane, hsel;
        logic [3:0]  ewen, ew;
        logic [69:0] ewb;
        for (int n = 0; n < 60; n++) begin
            idx  = $urandom_range(0, 2);
            lat  = lat_of(idx);
            kind = $urandom_range(0, 2);
            ld   = (kind == 0);
            st   = (kind == 1);
            sz   = 2'($urandom_range(0, 2));
            sg   = 1'($urandom_range(0, 1));
            rfw  = 1'($urandom_range(0, 1));
            dst  = 5'($urandom);
            alu  = $urandom; sd = $urandom; rd = $urandom; pc = $urandom;
            // Reference model in plain arithmetic
            mis  = (alu % (32'd1 << sz)) != 0;
            lane = alu % 4;
            hsel = (alu / 2) % 2;
            if (sz == 2'd0) begin
                v = (rd >> (8 * lane)) % 256;
                if (sg && v >= 128) v = v + 32'hFFFFFF00;
            end else if (sz == 2'd1) begin
                v = (rd >> (16 * hsel)) % 65536;
                if (sg && v >= 32768) v = v + 32'hFFFF0000;
            end else begin
                v = rd;
            end
            eres = ld ? v : alu;
            ewen = (st && !mis) ? ((sz == 2'd0) ? 4'(1 << lane) : (sz == 2'd1) ? 4'(3 << (2 * hsel)) : 4'd15) : 4'd0;
            ewd  = (sz == 2'd0) ? (sd % 256) * 32'h01010101 : (sz == 2'd1) ? (sd % 65536) * 32'h00010001 : sd;
            ewb  = {rfw & ~(ld & mis), dst, eres, pc};
            T    = (ld && !mis) ? lat + CAP : 0;
            d    = $urandom_range(1, lat + 3);
            set_bus(ld, st, sz, sg, sd, alu, rfw, dst, pc);
            dm_rdata = rd;
            for (int t = 0; t <= d; t++) begin
                MEM_valid = (t < d);
                @(negedge clk);
                eo = (t < d) && (t >= T);
                ew = (t == 0) ? ewen : 4'd0;
                ntotal++; if (over_a[idx] !== eo) $display("FAIL rnd%0d_over c%0d: got %b expected %b", n, t, over_a[idx], eo); else npass++;
                ntotal++; if (wen_a[idx] !== ew) $display("FAIL rnd%0d_wen c%0d: got %b expected %b", n, t, wen_a[idx], ew); else npass++;
                if (t == 0) begin
                    ntotal++; if (addr_a[idx] !== alu) $display("FAIL rnd%0d_addr: got %h expected %h", n, addr_a[idx], alu); else npass++;
                    ntotal++; if (pc_a[idx] !== pc) $display("FAIL rnd%0d_pc: got %h expected %h", n, pc_a[idx], pc); else npass++;
                end
                if (t == 0 && ewen != 4'd0) begin
                    ntotal++; if (wdata_a[idx] !== ewd) $display("FAIL rnd%0d_wdata: got %h expected %h", n, wdata_a[idx], ewd); else npass++;
                end
                if (eo) begin
                    ntotal++; if (exc_a[idx] !== (mis & (ld | st))) $display("FAIL rnd%0d_exc: got %b expected %b", n, exc_a[idx], mis & (ld | st)); else npass++;
                    ntotal++; if (wb_a[idx] !== ewb) $display("FAIL rnd%0d_wb c%0d: got %h expected %h", n, t, wb_a[idx], ewb); else npass++;
                end
                tick;
            end
        end
    endtask

    initial begin
        rst = 1'b1; MEM_valid = 1'b0; bus = '0; dm_rdata = '0;
        test_reset;
        test_lb;
        test_lhu;
        test_sh_hold;
        test_misaligned;
        test_flush_reset;
        test_lat0;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Next-generation memory stage for the multi-cycle MIPS core, sitting between EXE and WB.
- Decodes sub-word stores and loads for byte, half and word, with signed and unsigned loads.
- Handles misalignment detection and drives the byte-lane data-memory interface.
- Replaces the ad-hoc two-cycle load wait with a parametrised latency counter and a three-state handshake FSM.

Parameters:
- LOAD_LAT, 1, clock edges from address presentation to valid dm_rdata; legal range 0..7.
- CNT_W, 3, load-wait counter width; must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- MEM_valid  in  1  level from controller; held high until MEM_over is seen, then dropped.
- EXE_MEM_bus_r  in  107  {ld, st, size[1:0], sign, store_data[31:0], alu_result[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}; size codes: 00=byte, 01=half, 10=word.
- dm_rdata  in  32  data-memory read data.
- dm_addr  out  32  equals alu_result, always.
- dm_wen  out  4  byte-lane write enables.
- dm_wdata  out  32  lane-replicated store data.
- MEM_over  out  1  stage complete.
- MEM_exc  out  1  misaligned access flag; valid while MEM_over=1.
- MEM_WB_bus  out  70  {rf_wen_q, rf_wdest, mem_result, pc}.
- MEM_pc  out  32  pc.

Behaviour:
- FSM states: IDLE, WAIT, DONE. Reset → IDLE, counter=0, all registered outputs 0.
- Accept cycle (cycle 0): state=IDLE and MEM_valid=1.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0 → mis=1.
- Stores: dm_wen is non-zero only in the accept cycle with st=1 and mis=0.
  - byte: 1<<addr[1:0].
  - half: 0011 or 1100 by addr[1].
  - word: 1111.
- dm_wdata:
  - byte: {4{sd[7:0]}}.
  - half: {2{sd[15:0]}}.
  - word: sd.
  - Value is combinational and don't-care when dm_wen=0.
- Completion, non-load or (load with mis=1 or LOAD_LAT=0): MEM_over=1 combinationally in cycle 0; next state DONE if MEM_valid is still high.
- Completion, load with LOAD_LAT≥1: cycle 0 → WAIT with counter=LOAD_LAT-1.
  - WAIT decrements the counter.
  - MEM_over=1 in the WAIT cycle where counter=0, i.e. exactly LOAD_LAT cycles after cycle 0; then → DONE.
- DONE: MEM_over stays 1 while MEM_valid=1; MEM_valid=0 → IDLE. No repeated store writes in DONE.
- MEM_valid dropping in WAIT = flush: → IDLE, no MEM_over, no side effects.
- rst mid-operation: → IDLE next edge, MEM_over=0 from that cycle; a store already written is not undone.
- Load extraction:
  - byte lane = addr[1:0].
  - half lane = addr[1].
  - Zero- or sign-extend per the sign field.
  - mem_result = load result if ld, else alu_result.
- rf_wen_q = rf_wen & ~(ld & mis). MEM_exc = mis & (ld|st).
- Simultaneous events: rst has priority over everything; a MEM_valid re-assertion in the same cycle as the IDLE return is accepted next cycle only.

Optional Feature:
- Macro: MEM_LOAD_CAPTURE_EN.
- Defined:
  - Extracted load data is registered at the completion edge, so MEM_over and MEM_WB_bus appear one cycle later (LOAD_LAT+1).
  - The registered value is held stable through DONE regardless of dm_rdata changes.
  - The capture register resets to 0.
- Undefined: mem_result for loads is combinational from dm_rdata.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W.
  - FSM state enum.
  - bus-width constants (EXE_MEM_W=107, MEM_WB_W=70).
- Sub-module mem_lane_align: purely combinational store lane-enable/replication and load extract/extend, reused later by a cache path.

Test Plan:
- lb, sign=1, addr 0x1003, dm_rdata 0x80FF1234, LOAD_LAT=1 → MEM_over at cycle 1; mem_result 0xFFFFFF80.
- lhu, addr 0x2002, dm_rdata 0xBEEF0000 → mem_result 0x0000BEEF; MEM_exc=0.
- sh, addr 0x0006, sd 0x1234ABCD, MEM_valid held 3 cycles → dm_wen 1100 in cycle 0 only; dm_wdata 0xABCDABCD; MEM_over at cycles 0..2.
- sw, addr 0x0005 → dm_wen 0000; MEM_over and MEM_exc=1 in cycle 0. lw, addr 0x0002 → rf_wen_q=0.
- LOAD_LAT=3 lw: drop MEM_valid at cycle 2 → no MEM_over; rerun with rst at cycle 1 → IDLE and MEM_over=0 through cycle 3.
- LOAD_LAT=0 lw, dm_rdata 0xCAFEF00D → MEM_over and mem_result 0xCAFEF00D in cycle 0; with MEM_LOAD_CAPTURE_EN defined → at cycle 1.
